// File: rtl/argmax_stream_block_pkg.sv
// Shared definitions for the streaming argmax block: FSM encoding and
// the size derivations used by the top level and the lane reduction tree.
package argmax_stream_block_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int calc_index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_beats(input int n, input int l);
        return (n + l - 1) / l;
    endfunction

    function automatic int calc_count_width(input int b);
        return (b > 0) ? $clog2(b + 1) : 1;
    endfunction

    function automatic int calc_lane_width(input int l);
        return (l > 1) ? $clog2(l) : 1;
    endfunction

endpackage

// File: rtl/argmax_stream_block_max_lane_tree.sv
// Combinational pairwise reduction of one beat to its (max value, lane index).
// Masked lanes never win; on equal values the lower lane index is kept.
module max_lane_tree #(
    parameter int data_size   = 32,
    parameter int lanes       = 2,
    parameter int signed_mode = 1,
    parameter int lane_width  = 1
) (
    input  logic [lanes*data_size-1:0] data,
    input  logic [lanes-1:0]           mask,
    output logic [data_size-1:0]       max_value,
    output logic [lane_width-1:0]      max_lane
);

    localparam int depth  = $clog2(lanes);
    localparam int leaves = 1 << depth;

    function automatic logic greater(input logic [data_size-1:0] a,
                                     input logic [data_size-1:0] b);
        if (signed_mode != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    always_comb begin : reduce
        logic [data_size-1:0]  val [leaves];
        logic [lane_width-1:0] idx [leaves];
        logic [leaves-1:0]     ok;
        ok = '0;
        for (int k = 0; k < leaves; k++) begin
            val[k] = '0;
            idx[k] = '0;
            if (k < lanes) begin
                val[k] = data[k*data_size +: data_size];
                idx[k] = lane_width'(k);
                ok[k]  = mask[k];
            end
        end
        // Each level folds the right partner into the left slot; left lanes are lower.
        for (int step = 1; step < leaves; step = step * 2) begin
            for (int k = 0; k < leaves; k = k + 2 * step) begin
                if (!(ok[k] && (!ok[k+step] || !greater(val[k+step], val[k])))) begin
                    val[k] = val[k+step];
                    idx[k] = idx[k+step];
                    ok[k]  = ok[k+step];
                end
            end
        end
        max_value = val[0];
        max_lane  = idx[0];
    end

endmodule

// File: rtl/argmax_stream_block.sv
// Streaming argmax: accepts a vector as lane-parallel beats, tracks the running
// maximum and publishes (value, index) with a one-cycle done pulse.
module argmax_stream_block
    import argmax_stream_block_pkg::*;
#(
    parameter int data_size      = 32,
    parameter int number_of_data = 10,
    parameter int lanes          = 2,
    parameter int signed_mode    = 1
) (
    input  logic                                        clock_i,
    input  logic                                        reset_n_i,
    input  logic                                        start_i,
    input  logic                                        valid_i,
    input  logic [lanes*data_size-1:0]                  data_i,
    output logic                                        ready_o,
    output logic [data_size-1:0]                        data_max_o,
    output logic [calc_index_width(number_of_data)-1:0] index_max_o,
    output logic                                        max_tree_done_o,
    output logic                                        busy_o,
    output state_t                                      state_o
);

    localparam int index_width = calc_index_width(number_of_data);
    localparam int beats       = calc_beats(number_of_data, lanes);
    localparam int count_width = calc_count_width(beats);
    localparam int lane_width  = calc_lane_width(lanes);

    function automatic logic greater(input logic [data_size-1:0] a,
                                     input logic [data_size-1:0] b);
        if (signed_mode != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    state_t                   state;
    logic [count_width-1:0]   beat_cnt;
    logic [data_size-1:0]     run_val;
    logic [index_width-1:0]   run_idx;

    logic [lanes-1:0]         lane_mask;
    logic [data_size-1:0]     beat_val;
    logic [lane_width-1:0]    beat_lane;
    logic [31:0]              beat_index_full;
    logic [index_width-1:0]   beat_index;
    logic                     take_beat;
    logic                     last_beat;
    logic [data_size-1:0]     next_val;
    logic [index_width-1:0]   next_idx;

    // Lanes past the end of the vector only occur in the final beat.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < lanes; k++) begin
            lane_mask[k] = (int'(beat_cnt) * lanes + k) < number_of_data;
        end
    end

    max_lane_tree #(
        .data_size  (data_size),
        .lanes      (lanes),
        .signed_mode(signed_mode),
        .lane_width (lane_width)
    ) u_tree (
        .data     (data_i),
        .mask     (lane_mask),
        .max_value(beat_val),
        .max_lane (beat_lane)
    );

    assign beat_index_full = 32'(beat_cnt) * 32'(lanes) + 32'(beat_lane);
    assign beat_index      = beat_index_full[index_width-1:0];

    // Earlier beats hold lower indices, so only a strictly larger beat value replaces.
    assign take_beat = (beat_cnt == '0) || greater(beat_val, run_val);
    assign last_beat = (beat_cnt == count_width'(beats - 1));
    assign next_val  = take_beat ? beat_val   : run_val;
    assign next_idx  = take_beat ? beat_index : run_idx;

    assign ready_o = (state == ST_ACCUM);
    assign busy_o  = (state != ST_IDLE);
    assign state_o = state;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state           <= ST_IDLE;
            beat_cnt        <= '0;
            run_val         <= '0;
            run_idx         <= '0;
            data_max_o      <= '0;
            index_max_o     <= '0;
            max_tree_done_o <= 1'b0;
        end else begin
            max_tree_done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state    <= ST_ACCUM;
                        beat_cnt <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (valid_i) begin
                        run_val <= next_val;
                        run_idx <= next_idx;
                        if (last_beat) begin
                            state           <= ST_DONE;
                            beat_cnt        <= '0;
                            data_max_o      <= next_val;
                            index_max_o     <= next_idx;
                            max_tree_done_o <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + count_width'(1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_stream_block.sv
// Bench for argmax_stream_block: three configurations (2-lane signed,
// 3-lane signed, 2-lane unsigned) driven one vector at a time.
module tb_argmax_stream_block;
    import argmax_stream_block_pkg::*;

    localparam int n = 10;

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] val;
        logic [3:0]  idx;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_s [3];
    logic        valid_s [3];
    logic [95:0] data_s  [3];
    logic        ready_w [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic [31:0] max_w   [3];
    logic [3:0]  idx_w   [3];
    state_t      state_w [3];

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   lanes_of [3] = '{2, 3, 2};

    logic [31:0] v_basic [10] = '{3, 7, 1, 9, 2, 0, 5, 4, 8, 6};
    logic [31:0] v_neg   [10] = '{-10, -5, -7, -3, -20, -8, -4, -6, -9, -2};
    logic [31:0] v_sign  [10] = '{32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] v_five  [10] = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    logic [31:0] v_ramp  [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    logic [31:0] v_mid   [10] = '{1, 2, 3, 4, 50, 6, 7, 8, 9, 10};
    logic [31:0] v_tie   [10] = '{2, 8, 8, 1, 0, 3, 8, 7, 6, 5};

    always #5 clk = ~clk;

    argmax_stream_block #(.data_size(32), .number_of_data(n), .lanes(2), .signed_mode(1)) u_dut_a (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start_s[0]), .valid_i(valid_s[0]),
        .data_i(data_s[0][63:0]), .ready_o(ready_w[0]), .data_max_o(max_w[0]),
        .index_max_o(idx_w[0]), .max_tree_done_o(done_w[0]), .busy_o(busy_w[0]), .state_o(state_w[0]));

    argmax_stream_block #(.data_size(32), .number_of_data(n), .lanes(3), .signed_mode(1)) u_dut_b (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start_s[1]), .valid_i(valid_s[1]),
        .data_i(data_s[1]), .ready_o(ready_w[1]), .data_max_o(max_w[1]),
        .index_max_o(idx_w[1]), .max_tree_done_o(done_w[1]), .busy_o(busy_w[1]), .state_o(state_w[1]));

    argmax_stream_block #(.data_size(32), .number_of_data(n), .lanes(2), .signed_mode(0)) u_dut_c (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(start_s[2]), .valid_i(valid_s[2]),
        .data_i(data_s[2][63:0]), .ready_o(ready_w[2]), .data_max_o(max_w[2]),
        .index_max_o(idx_w[2]), .max_tree_done_o(done_w[2]), .busy_o(busy_w[2]), .state_o(state_w[2]));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding vector.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done_w[d] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: dut %0d pulsed done with nothing outstanding", d);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_dut", 64'(d), 64'(mon_e.dut));
                    check("data_max", 64'(max_w[d]), 64'(mon_e.val));
                    check("index_max", 64'(idx_w[d]), 64'(mon_e.idx));
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            check({tag, "_data_max"}, 64'(max_w[d]), 64'd0);
            check({tag, "_index_max"}, 64'(idx_w[d]), 64'd0);
            check({tag, "_done"}, 64'(done_w[d]), 64'd0);
            check({tag, "_ready"}, 64'(ready_w[d]), 64'd0);
            check({tag, "_busy"}, 64'(busy_w[d]), 64'd0);
        end
    endtask

    // abort_after >= 0 pulls reset before that beat and expects no result.
    task automatic run_vector(input int d, input logic [31:0] el [10], input bit gaps,
                              input bit poke, input logic [31:0] exp_val,
                              input logic [3:0] exp_idx, input int abort_after);
        int   lanes_n;
        int   nb;
        int   waited;
        int   eidx;
        bit   acc;
        exp_t e;
        lanes_n = lanes_of[d];
        nb = (n + lanes_n - 1) / lanes_n;
        if (poke) begin
            valid_s[d] = 1'b1;
            data_s[d]  = {3{32'd1000}};
            repeat (2) @(posedge clk);
            #1;
            check("idle_ignores_valid", 64'(state_w[d]), 64'(ST_IDLE));
            valid_s[d] = 1'b0;
        end
        if (abort_after < 0) begin
            e.dut = d[1:0];
            e.val = exp_val;
            e.idx = exp_idx;
            exp_q.push_back(e);
        end
        start_s[d] = 1'b1;
        @(posedge clk);
        #1;
        start_s[d] = 1'b0;
        check("ready_after_start", 64'(ready_w[d]), 64'd1);
        for (int b = 0; b < nb; b++) begin
            if (abort_after == b) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            if (gaps && b > 0) begin
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < lanes_n; k++) begin
                eidx = b * lanes_n + k;
                data_s[d][k*32 +: 32] = (eidx < n) ? el[eidx] : 32'h7FFF_FFFF;
            end
            valid_s[d] = 1'b1;
            if (poke && b == 2) start_s[d] = 1'b1;
            waited = 0;
            acc = 1'b0;
            while (!acc && waited < 20) begin
                acc = ready_w[d];
                @(posedge clk);
                #1;
                waited++;
            end
            valid_s[d] = 1'b0;
            start_s[d] = 1'b0;
            if (!acc) begin
                tests++;
                fails++;
                $display("FAIL beat_timeout: dut %0d beat %0d not accepted, ready stayed %0b", d, b, ready_w[d]);
            end
        end
        check("done_latency", 64'(done_w[d]), 64'd1);
        check("busy_in_done", 64'(busy_w[d]), 64'd1);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done_w[d]), 64'd0);
        check("idle_after_done", 64'(busy_w[d]), 64'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            start_s[d] = 1'b0;
            valid_s[d] = 1'b0;
            data_s[d]  = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_state", 64'(state_w[0]), 64'(ST_IDLE));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_vector(0, v_basic, 1'b0, 1'b0, 32'd9, 4'd3, -1);
        run_vector(1, v_neg,   1'b0, 1'b0, 32'hFFFF_FFFE, 4'd9, -1);
        run_vector(2, v_sign,  1'b0, 1'b0, 32'hFFFF_FFFF, 4'd0, -1);
        run_vector(0, v_sign,  1'b0, 1'b0, 32'd1, 4'd1, -1);
        run_vector(0, v_five,  1'b0, 1'b0, 32'd5, 4'd0, -1);
        run_vector(0, v_five,  1'b1, 1'b0, 32'd5, 4'd0, -1);
        run_vector(1, v_five,  1'b0, 1'b0, 32'd5, 4'd0, -1);
        run_vector(0, v_ramp,  1'b0, 1'b0, 32'd0, 4'd0, 2);
        run_vector(0, v_ramp,  1'b0, 1'b0, 32'd9, 4'd9, -1);
        run_vector(1, v_ramp,  1'b0, 1'b0, 32'd9, 4'd9, -1);
        run_vector(1, v_mid,   1'b0, 1'b0, 32'd50, 4'd4, -1);
        run_vector(0, v_tie,   1'b0, 1'b1, 32'd8, 4'd1, -1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/argmax_stream_block.md
ARGMAX_STREAM_BLOCK -- requirements
Module: argmax_stream_block

Interface
REQ-001 Parameter data_size, default 32, bits per element.
REQ-002 Parameter number_of_data, default 10, elements per vector (categories); legal range 2..255.
REQ-003 Parameter lanes, default 2, elements accepted per beat; legal range 1..number_of_data.
REQ-004 Parameter signed_mode, default 1; 1 = two's-complement compare, 0 = unsigned compare.
REQ-005 Derived constant index_width = max(1, clog2(number_of_data)); beats = ceil(number_of_data / lanes).
REQ-006 clock_i  input  1  single clock, rising edge.
REQ-007 reset_n_i  input  1  reset, asynchronous, active-low.
REQ-008 start_i  input  1  one-cycle request to begin a new vector.
REQ-009 valid_i  input  1  data_i holds a valid beat.
REQ-010 data_i  input  lanes*data_size  beat; lane k at bits [k*data_size +: data_size] is element beat*lanes+k.
REQ-011 ready_o  output  1  block accepts a beat this cycle.
REQ-012 data_max_o  output  data_size  maximum element of the last completed vector.
REQ-013 index_max_o  output  index_width  element index (0-based) of that maximum.
REQ-014 max_tree_done_o  output  1  one-cycle pulse: data_max_o/index_max_o valid and updated.
REQ-015 busy_o  output  1  vector in progress.

Function
REQ-016 FSM states IDLE, ACCUM, DONE; reset state IDLE.
REQ-017 IDLE: start_i=1 -> ACCUM, beat counter cleared, running max invalid; start_i while not IDLE is ignored.
REQ-018 ready_o = 1 only in ACCUM; a beat is accepted on a cycle with valid_i && ready_o; valid_i outside ACCUM is ignored.
REQ-019 Each accepted beat: combinational lane reduction yields (value, index) of beat; merged into running max in the same edge.
REQ-020 Final beat: lanes whose element index >= number_of_data are excluded from comparison.
REQ-021 Compare per signed_mode; strictly greater replaces; on equal values the lower index wins (within a beat and across beats).
REQ-022 First accepted beat loads running max unconditionally (no dependency on prior contents).
REQ-023 After beat number beats is accepted: FSM -> DONE; next cycle data_max_o/index_max_o hold the result and max_tree_done_o = 1 for exactly that cycle; FSM -> IDLE.
REQ-024 Latency: max_tree_done_o asserted 1 cycle after the edge accepting the last beat; back-to-back vectors: start_i accepted in the IDLE cycle following DONE.
REQ-025 data_max_o/index_max_o change only at the DONE update; held until next vector completes.
REQ-026 busy_o = 1 in ACCUM and DONE.
REQ-027 Beat counter width = clog2(beats+1); no wrap possible within a vector.

Reset
REQ-028 reset_n_i low asynchronously forces IDLE, beat counter 0, running max 0, data_max_o 0, index_max_o 0, max_tree_done_o 0, ready_o 0, busy_o 0.
REQ-029 Reset mid-vector discards partial result; no done pulse is generated for the aborted vector.
REQ-030 Deassertion of reset takes effect at the next rising edge; first start_i honoured on that edge or later.

Structure
REQ-031 Shared package holds FSM state encoding and the index_width/beats derivation functions.
REQ-032 One sub-module max_lane_tree: combinational log-depth reduction over lanes with valid mask, returns max value and lane index, lower index on tie.
REQ-033 Top module holds FSM, beat counter, running max registers and output registers only.

Verification
REQ-034 lanes=2, N=10, signed: start, beats {3,7},{1,9},{2,0},{5,4},{8,6} no gaps -> done 1 cycle after 5th beat, data_max_o=9, index_max_o=3.
REQ-035 lanes=3, N=10, signed: 4 beats, last beat lanes 1..2 = 0x7FFFFFFF, elements 0..9 all negative with max -2 at index 9 -> data_max_o=-2, index_max_o=9 (padding ignored).
REQ-036 signed_mode=0 vs 1, elements {0xFFFFFFFF, 1, ...0}: unsigned -> index 0; signed -> index 1.
REQ-037 Ties: all ten elements = 5 -> index_max_o=0; valid_i toggled every other cycle -> same result, done after 5 accepted beats.
REQ-038 Reset asserted after 2 beats, released, new vector {0..9} -> no done for aborted vector; result 9 @ index 9; outputs 0 during reset.
REQ-039 start_i pulsed during ACCUM and valid_i in IDLE -> no effect on counter or result.
